// File: rtl/uart_start_bit_if.sv
// Serial-line side of the uart_rx start-bit stage: oversample tick, raw line and frame-done in,
// start / false-start pulses and busy level out.
interface uart_start_bit_if;
  logic i_en;
  logic i_rx;
  logic i_frame_done;
  logic o_start;
  logic o_false_start;
  logic o_busy;

  modport master (
    output i_en, i_rx, i_frame_done,
    input  o_start, o_false_start, o_busy
  );

  modport slave (
    input  i_en, i_rx, i_frame_done,
    output o_start, o_false_start, o_busy
  );
endinterface

// File: rtl/uart_start_bit.sv
// Purpose: synchronise rx, detect start-bit falling edge, validate by 3-sample mid-bit majority vote.
// Latency: SYNC_STAGES cycles line->rx_s; o_start/o_false_start one cycle after the k=OSR/2+1 tick.
// Backpressure: none; re-arming is held off until frame_done and the line is seen high on a tick.
module uart_start_bit #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  uart_start_bit_if.slave  bus
);

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] K_V0  = CW'(OSR/2 - 1);
  localparam logic [CW-1:0] K_V1  = CW'(OSR/2);
  localparam logic [CW-1:0] K_DEC = CW'(OSR/2 + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VERIFY = 2'd1,
    FRAME  = 2'd2,
    REARM  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt_q, cnt_d, k_now;
  logic                   v0_q, v1_q, v0_d, v1_d;
  logic                   vote_low;
  logic                   start_q, false_q, busy_q;
  logic                   start_d, false_d, busy_d;

  // Sync chain resets to idle-high so a reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_rx};
  end

  assign rx_s  = sync_q[SYNC_STAGES-1];
  assign k_now = cnt_q + CW'(1);

  // Third vote is the sample taken on the decision tick itself.
  assign vote_low = (~v0_q & ~v1_q) | (~v0_q & ~rx_s) | (~v1_q & ~rx_s);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      start_q <= 1'b0;
      false_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      start_q <= start_d;
      false_q <= false_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_en && !rx_s) begin
          state_d = VERIFY;
          cnt_d   = '0;
        end
      end
      VERIFY: begin
        if (bus.i_en) begin
          cnt_d = k_now;
          if (k_now == K_V0) v0_d = rx_s;
          if (k_now == K_V1) v1_d = rx_s;
          if (k_now == K_DEC) state_d = vote_low ? FRAME : IDLE;
        end
      end
      // Frame-done is a level/pulse from the stop-bit stage, so it is not tick-gated.
      FRAME: begin
        if (bus.i_frame_done) state_d = REARM;
      end
      REARM: begin
        if (bus.i_en && rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    false_d = 1'b0;
    busy_d  = (state_d != IDLE);
    if (state_q == VERIFY && bus.i_en && k_now == K_DEC) begin
      start_d = vote_low;
      false_d = ~vote_low;
    end
  end

  assign bus.o_start       = start_q;
  assign bus.o_false_start = false_q;
  assign bus.o_busy        = busy_q;

endmodule

// File: tb/tb_uart_start_bit.sv
// Bench for uart_start_bit: randomized line patterns on a tick grid (i_en every 4th cycle),
// checked against a tick-level model of the start-bit rules.
module tb_uart_start_bit;
  localparam int OSR   = 16;
  localparam int K_DEC = OSR/2 + 1;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   mon_st = 0, mon_fs = 0, mon_both = 0;
  int   exp_st = 0, exp_fs = 0;

  // Model state: armed = waiting for edge, m_edge = ticks since edge (-1 when not verifying)
  bit   m_armed, m_frame, m_wait;
  int   m_edge, m_zeros;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_start_bit_if bus ();

  uart_start_bit #(.OSR(OSR), .SYNC_STAGES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.o_start)                       mon_st   <= mon_st + 1;
    if (bus.o_false_start)                 mon_fs   <= mon_fs + 1;
    if (bus.o_start && bus.o_false_start)  mon_both <= mon_both + 1;
  end

  task automatic model_reset();
    m_armed = 1'b1; m_frame = 1'b0; m_wait = 1'b0; m_edge = -1; m_zeros = 0;
  endtask

  // Expected {start, false_start, busy} right after a tick with line value rx.
  task automatic model_tick(input logic rx, input logic fd, output logic [2:0] expv);
    bit st, fs, was_frame;
    st = 0; fs = 0; was_frame = m_frame;
    if (m_armed) begin
      if (!rx) begin m_armed = 0; m_edge = 0; m_zeros = 0; end
    end else if (m_edge >= 0) begin
      m_edge++;
      if (m_edge >= K_DEC - 2 && m_edge <= K_DEC && !rx) m_zeros++;
      if (m_edge == K_DEC) begin
        m_edge = -1;
        if (m_zeros >= 2) begin st = 1; m_frame = 1; end
        else begin fs = 1; m_armed = 1; end
      end
    end else if (m_wait && rx) begin
      m_wait = 0; m_armed = 1;
    end
    if (fd && was_frame) begin m_frame = 0; m_wait = 1; end
    exp_st += st; exp_fs += fs;
    expv = {st, fs, !m_armed};
  endtask

  task automatic do_tick(input logic rx, input logic fd, output logic [2:0] obs);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.i_rx = rx;
      bus.i_en = (c == 3);
      bus.i_frame_done = (c == 3) ? fd : 1'b0;
    end
    @(posedge clk); #1;
    obs = {bus.o_start, bus.o_false_start, bus.o_busy};
    bus.i_en = 1'b0;
    bus.i_frame_done = 1'b0;
  endtask

  task automatic pulse_fd();
    @(negedge clk);
    bus.i_en = 1'b0; bus.i_frame_done = 1'b1;
    @(negedge clk);
    bus.i_frame_done = 1'b0;
    if (m_frame) begin m_frame = 0; m_wait = 1; end
  endtask

  task automatic test_reset();
    logic [2:0] obs, expv;
    rst = 1'b1; bus.i_en = 1'b0; bus.i_rx = 1'b1; bus.i_frame_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    total++;
    if ({bus.o_start, bus.o_false_start, bus.o_busy} !== 3'b000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=000", {bus.o_start, bus.o_false_start, bus.o_busy});
    end
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL reset_idle i=%0d got=%b exp=%b", i, obs, expv); end
    end
  endtask

  task automatic test_clean();
    logic [2:0] obs, expv;
    logic rx;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
        if (obs !== expv) begin bad++; $display("FAIL clean_idle it=%0d got=%b exp=%b", it, obs, expv); end
      end
      for (int k = 0; k < OSR; k++) begin
        do_tick(1'b0, 1'b0, obs); model_tick(1'b0, 1'b0, expv); total++;
        if (obs !== expv) begin bad++; $display("FAIL clean it=%0d k=%0d got=%b exp=%b", it, k, obs, expv); end
        if (k == K_DEC) begin
          @(posedge clk); #1; total++;
          if (bus.o_start !== 1'b0) begin bad++; $display("FAIL clean_width got=%b exp=0", bus.o_start); end
        end
      end
      for (int k = 0; k < 6; k++) begin
        rx = 1'($urandom_range(0, 1));
        do_tick(rx, 1'b0, obs); model_tick(rx, 1'b0, expv); total++;
        if (obs !== expv) begin bad++; $display("FAIL clean_frame it=%0d got=%b exp=%b", it, obs, expv); end
      end
      // frame_done coinciding with a high-line tick must not skip the rearm tick
      do_tick(1'b1, 1'b1, obs); model_tick(1'b1, 1'b1, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL clean_fd_tick it=%0d got=%b exp=%b", it, obs, expv); end
      do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL clean_rearm it=%0d got=%b exp=%b", it, obs, expv); end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] obs, expv;
    int len;
    logic rx;
    for (int it = 0; it < 4; it++) begin
      len = (it == 0) ? 3 : int'($urandom_range(1, 6));
      for (int t = 0; t < 12; t++) begin
        rx = (t < len) ? 1'b0 : 1'b1;
        do_tick(rx, 1'b0, obs); model_tick(rx, 1'b0, expv); total++;
        if (obs !== expv) begin bad++; $display("FAIL glitch len=%0d t=%0d got=%b exp=%b", len, t, obs, expv); end
      end
    end
  endtask

  task automatic test_vote();
    logic [2:0] obs, expv;
    logic [2:0] pat;
    logic rx, fd;
    for (int it = 0; it < 12; it++) begin
      pat = (it < 8) ? 3'(it) : 3'($urandom_range(0, 7));
      for (int k = 0; k <= K_DEC; k++) begin
        if (k == 0)            rx = 1'b0;
        else if (k < K_DEC - 2) rx = 1'($urandom_range(0, 1));
        else                   rx = pat[k - (K_DEC - 2)];
        fd = (k > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        do_tick(rx, fd, obs); model_tick(rx, fd, expv); total++;
        if (obs !== expv) begin bad++; $display("FAIL vote pat=%b k=%0d got=%b exp=%b", pat, k, obs, expv); end
      end
      if (m_frame) pulse_fd();
      do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL vote_end pat=%b got=%b exp=%b", pat, obs, expv); end
    end
  endtask

  task automatic test_break();
    logic [2:0] obs, expv;
    for (int k = 0; k <= K_DEC; k++) begin
      do_tick(1'b0, 1'b0, obs); model_tick(1'b0, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL break_first k=%0d got=%b exp=%b", k, obs, expv); end
    end
    pulse_fd();
    for (int t = 0; t < 50; t++) begin
      do_tick(1'b0, 1'b0, obs); model_tick(1'b0, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL break_held t=%0d got=%b exp=%b", t, obs, expv); end
    end
    do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
    if (obs !== expv) begin bad++; $display("FAIL break_high got=%b exp=%b", obs, expv); end
    for (int k = 0; k <= K_DEC; k++) begin
      do_tick(1'b0, 1'b0, obs); model_tick(1'b0, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL break_second k=%0d got=%b exp=%b", k, obs, expv); end
    end
    pulse_fd();
    do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv);
  endtask

  task automatic test_reset_mid();
    logic [2:0] obs, expv;
    for (int k = 0; k <= 5; k++) begin
      do_tick(1'b0, 1'b0, obs); model_tick(1'b0, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL rstmid_pre k=%0d got=%b exp=%b", k, obs, expv); end
    end
    @(negedge clk);
    rst = 1'b1; bus.i_en = 1'b0; bus.i_rx = 1'b1;
    @(posedge clk); #1; total++;
    if ({bus.o_start, bus.o_false_start, bus.o_busy} !== 3'b000) begin
      bad++; $display("FAIL rstmid_now got=%b exp=000", {bus.o_start, bus.o_false_start, bus.o_busy});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int t = 0; t < 14; t++) begin
      do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL rstmid_post t=%0d got=%b exp=%b", t, obs, expv); end
    end
  endtask

  task automatic test_en_hold();
    logic [2:0] obs, expv;
    int moved;
    moved = 0;
    @(negedge clk);
    bus.i_rx = 1'b0; bus.i_en = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bus.o_busy || bus.o_start || bus.o_false_start) moved++;
    end
    total++;
    if (moved !== 0) begin bad++; $display("FAIL en_hold active_cycles got=%0d exp=0", moved); end
    for (int k = 0; k <= K_DEC; k++) begin
      do_tick(1'b0, 1'b0, obs); model_tick(1'b0, 1'b0, expv); total++;
      if (obs !== expv) begin bad++; $display("FAIL en_hold_tick k=%0d got=%b exp=%b", k, obs, expv); end
    end
    pulse_fd();
    do_tick(1'b1, 1'b0, obs); model_tick(1'b1, 1'b0, expv); total++;
    if (obs !== expv) begin bad++; $display("FAIL en_hold_end got=%b exp=%b", obs, expv); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_vote();
    test_break();
    test_reset_mid();
    test_en_hold();
    repeat (3) @(negedge clk);
    total++;
    if (mon_both !== 0) begin bad++; $display("FAIL both_pulses got=%0d exp=0", mon_both); end
    total++;
    if (mon_st !== exp_st) begin bad++; $display("FAIL start_count got=%0d exp=%0d", mon_st, exp_st); end
    total++;
    if (mon_fs !== exp_fs) begin bad++; $display("FAIL false_count got=%0d exp=%0d", mon_fs, exp_fs); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
